uart_core: RTL and testbench
============================

# uart_core

Parametrised full-duplex UART: a transmit FSM and a receive FSM sharing one clock, with valid/ready handshakes toward the fabric in both directions. It generalises the fixed 8N1 design to configurable bit period, data width and stop-bit count, adds optional parity, and reports framing, parity and overrun errors. It sits between the board UART pins and any byte-stream consumer or producer (command parser, FIFO, LED/debug logic).

## Interface
- CLKS_PER_BIT, 234: clock cycles per bit (27 MHz / 115200); legal ≥ 4.
- DATA_BITS, 8: data bits per frame; legal 5..8.
- STOP_BITS, 1: stop bits transmitted; legal 1 or 2. RX always checks only the first stop bit.
- PARITY_ODD, 0: 0 = even, 1 = odd. Meaningful only with UART_PARITY_EN.
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- uart_rx  in  1  serial input; asynchronous to clk.
- uart_tx  out  1  serial output; idles high.
- tx_data  in  DATA_BITS  byte to send; sampled on accept.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX idle, can accept.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data and error flags valid; held until taken.
- rx_ready  in  1  consumer takes the byte.
- rx_frame_err  out  1  first stop bit sampled low; qualified by rx_valid.
- rx_parity_err  out  1  parity mismatch; qualified by rx_valid.
- rx_overrun  out  1  one-cycle pulse when a completed byte is dropped.

## Operation
- Reset values: uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error outputs 0. Synchroniser flops reset to 1. All counters reset to 0. Both FSMs reset to IDLE.
- Reset asserted mid-frame aborts the frame. uart_tx returns high asynchronously. No partial byte is delivered.
- TX states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - tx_ready=1 only in IDLE. Accept = tx_valid && tx_ready; tx_data is latched on accept.
  - START drives 0. DATA drives bits LSB first. PARITY drives the XOR of the data bits, inverted when PARITY_ODD=1. STOP drives 1 for STOP_BITS×CLKS_PER_BIT cycles.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- RX path: uart_rx passes through a 2-flop synchroniser. The FSM uses only the synchronised value.
- RX states: IDLE → START → DATA → [PARITY] → STOP → IDLE. STOP can also go to BREAK.
  - IDLE: leaves on the synchronised input low.
  - START: waits CLKS_PER_BIT/2 cycles (integer division), then resamples. If high, it is a false start: return to IDLE with no output.
  - DATA and PARITY: one sample every CLKS_PER_BIT cycles at bit centre, shifted in LSB first.
  - STOP: samples at the stop-bit centre.
    - On a low sample: frame error, go to BREAK.
    - Otherwise go to IDLE immediately, without waiting for the end of the stop bit.
  - BREAK: waits for the synchronised input high, then goes to IDLE.
- RX delivery happens at the stop sample:
  - If rx_valid=0: load rx_data and both error flags, and set rx_valid.
  - If rx_valid=1 and rx_ready=0: discard the new byte, keep the old byte and flags, and pulse rx_overrun.
- rx_valid && rx_ready clears rx_valid on the next edge.
- If a take and a new delivery fall in the same cycle, the new byte is loaded and rx_valid stays 1. No overrun is reported.
- A frame-error byte is still delivered, with rx_frame_err=1.

## Timing
- TX: uart_tx goes low on the first edge after accept.
- TX frame length, from the first start-bit cycle to the last stop cycle: (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT, where P=1 with parity, else 0.
- TX leaves STOP directly into IDLE. tx_ready rises the cycle after the last stop cycle. Back-to-back frames therefore carry one extra idle-high cycle.
- RX: rx_valid rises one cycle after the stop-bit centre sample. The synchroniser adds 2 cycles of input latency.
- Bit counter width: $clog2(DATA_BITS+1). Baud counter width: $clog2(CLKS_PER_BIT+1). Both wrap to 0 at terminal count with no modulo drift.
- TX and RX are fully independent. Simultaneous activity has no interaction.

## Configuration
- UART_PARITY_EN defined:
  - PARITY states are present in both FSMs.
  - TX inserts the parity bit. RX checks it and drives rx_parity_err.
- UART_PARITY_EN undefined:
  - No PARITY states exist. PARITY_ODD is ignored.
  - rx_parity_err is tied to 0. Frames are DATA_BITS + stop bits only.

## Structure
- uart_pkg holds:
  - TX and RX state enums and their encodings.
  - Legal-range checks for DATA_BITS and STOP_BITS (elaboration-time).
  - Parity helper function.
- One sub-module, uart_sync2: 2-flop synchroniser with reset value 1. It is reusable for btn inputs.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8.
- TX 0x55, 8N1: uart_tx low for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high. tx_ready returns 161 cycles after accept.
- RX loopback (uart_tx→uart_rx), bytes 0x00, 0xFF, 0xA5 back-to-back: each byte appears on rx_data with rx_valid. No errors.
- Low pulse of 5 cycles on uart_rx: false start. rx_valid stays 0 and the FSM returns to IDLE.
- Hold rx_ready=0 and send 0x12 then 0x34: rx_data stays 0x12 and rx_overrun pulses exactly once.
- Stop bit forced low, then line held low for 100 cycles: byte delivered with rx_frame_err=1. No new frame starts until the line goes high.
- With UART_PARITY_EN and PARITY_ODD=0, send 0x07 with the parity bit forced to 0: rx_parity_err=1. The same stimulus with parity bit 1 gives rx_parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encodings, configuration check and parity helper for uart_core.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rx_state_t;
`else
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rx_state_t;
`endif

   function automatic bit cfg_legal(input int clks, input int data_bits,
                                    input int stop_bits, input int parity_odd);
      return (clks >= 4) && (data_bits >= 5) && (data_bits <= 8) &&
             (stop_bits >= 1) && (stop_bits <= 2) &&
             (parity_odd >= 0) && (parity_odd <= 1);
   endfunction

   // Data narrower than 8 bits is zero-padded by the caller, which leaves the XOR unchanged.
   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser that resets to 1 so an idle-high line never looks like a start bit.
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART with valid/ready handshakes and frame/parity/overrun reporting.
// Define UART_PARITY_EN to add a parity bit to both directions.
module uart_core #(
   parameter int CLKS_PER_BIT = 234,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);
   import uart_pkg::*;

   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   if (!cfg_legal(CLKS_PER_BIT, DATA_BITS, STOP_BITS, PARITY_ODD)) begin : g_bad_cfg
      $error("uart_core: illegal CLKS_PER_BIT/DATA_BITS/STOP_BITS/PARITY_ODD");
   end

   tx_state_t            tx_state, tx_next;
   logic [BAUD_W-1:0]    tx_baud;
   logic [BIT_W-1:0]     tx_bit;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_baud_done;

   assign tx_baud_done = (tx_baud == BAUD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tx_state <= TX_IDLE;
      else        tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:   if (tx_valid) tx_next = TX_START;
         TX_START:  if (tx_baud_done) tx_next = TX_DATA;
         TX_DATA:   if (tx_baud_done && tx_bit == DATA_LAST)
`ifdef UART_PARITY_EN
                       tx_next = TX_PARITY;
         TX_PARITY: if (tx_baud_done) tx_next = TX_STOP;
`else
                       tx_next = TX_STOP;
`endif
         TX_STOP:   if (tx_baud_done && tx_bit == STOP_LAST) tx_next = TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   // The bit counter restarts on every state change, so it also counts the stop bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_baud  <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else begin
         if (tx_state == TX_IDLE || tx_baud_done) tx_baud <= '0;
         else                                     tx_baud <= tx_baud + BAUD_W'(1);
         if (tx_state == TX_IDLE)  tx_bit <= '0;
         else if (tx_baud_done)    tx_bit <= (tx_next != tx_state) ? '0 : tx_bit + BIT_W'(1);
         if (tx_state == TX_IDLE && tx_valid)           tx_shift <= tx_data;
         else if (tx_state == TX_DATA && tx_baud_done)  tx_shift <= tx_shift >> 1;
      end
   end

`ifdef UART_PARITY_EN
   logic       tx_par;
   logic [7:0] tx_pad;

   always_comb begin
      tx_pad = '0;
      tx_pad[DATA_BITS-1:0] = tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             tx_par <= 1'b0;
      else if (tx_state == TX_IDLE && tx_valid) tx_par <= parity_of(tx_pad, 1'(PARITY_ODD));
   end
`endif

   always_comb begin
      uart_tx  = 1'b1;
      tx_ready = 1'b0;
      case (tx_state)
         TX_IDLE:   tx_ready = 1'b1;
         TX_START:  uart_tx  = 1'b0;
         TX_DATA:   uart_tx  = tx_shift[0];
`ifdef UART_PARITY_EN
         TX_PARITY: uart_tx  = tx_par;
`endif
         default:   uart_tx  = 1'b1;
      endcase
   end

   logic                 rx_s;
   rx_state_t            rx_state, rx_next;
   logic [BAUD_W-1:0]    rx_baud;
   logic [BIT_W-1:0]     rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_tick, rx_deliver, par_err;

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (uart_rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:   if (!rx_s) rx_next = RX_START;
         RX_START:  if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:   if (rx_tick && rx_bit == DATA_LAST)
`ifdef UART_PARITY_EN
                       rx_next = RX_PARITY;
         RX_PARITY: if (rx_tick) rx_next = RX_STOP;
`else
                       rx_next = RX_STOP;
`endif
         RX_STOP:   if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_BREAK;
         RX_BREAK:  if (rx_s) rx_next = RX_IDLE;
         default:   rx_next = RX_IDLE;
      endcase
   end

   // START samples at half a bit; every later sample lands one full bit further on, at bit centre.
   always_comb begin
      rx_tick = 1'b0;
      case (rx_state)
         RX_IDLE, RX_BREAK: rx_tick = 1'b0;
         RX_START:          rx_tick = (rx_baud == HALF_LAST);
         default:           rx_tick = (rx_baud == BAUD_LAST);
      endcase
      rx_deliver = (rx_state == RX_STOP) && rx_tick;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_baud  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         if (rx_state == RX_IDLE || rx_state == RX_BREAK || rx_tick) rx_baud <= '0;
         else                                                        rx_baud <= rx_baud + BAUD_W'(1);
         if (rx_tick) rx_bit <= (rx_next != rx_state) ? '0 : rx_bit + BIT_W'(1);
         if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
      end
   end

`ifdef UART_PARITY_EN
   logic       rx_par;
   logic [7:0] rx_pad;

   always_comb begin
      rx_pad = '0;
      rx_pad[DATA_BITS-1:0] = rx_shift;
      par_err = (rx_par != parity_of(rx_pad, 1'(PARITY_ODD)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              rx_par <= 1'b0;
      else if (rx_state == RX_PARITY && rx_tick) rx_par <= rx_s;
   end
`else
   assign par_err = 1'b0;
`endif

   // A take coinciding with a delivery lets the new byte in; only an untaken old byte causes a drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (rx_deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_valid      <= 1'b1;
               rx_data       <= rx_shift;
               rx_frame_err  <= !rx_s;
               rx_parity_err <= par_err;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: a frame-level TX waveform model and an RX byte scoreboard.
// Define UART_PARITY_EN for both bench and RTL to include the parity scenario.
`timescale 1ns/1ps
module tb_uart_core;

   localparam int CPB   = 16;
   localparam int DBITS = 8;
   localparam int SBITS = 1;
   localparam int ODD   = 0;
`ifdef UART_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int FRAME_CYC = (1 + DBITS + PBITS + SBITS) * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_tx, tx_ready, rx_valid, rx_frame_err, rx_parity_err, rx_overrun;
   logic [7:0] rx_data;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b1;
   logic       rx_line = 1'b1;
   logic       loopback = 1'b0;
   logic       uart_rx;
`ifdef UART_PARITY_EN
   logic       par_ovr_en = 1'b0;
   logic       par_force = 1'b0;
`endif

   assign uart_rx = loopback ? uart_tx : rx_line;

   int n_cmp = 0;
   int n_bad = 0;
   int ovr_seen = 0;

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       pe;
   } rx_exp_t;

   rx_exp_t     rx_q[$];
   rx_exp_t     exp_item;
   int          m_pos = -1;
   logic [15:0] m_frame = '1;

   uart_core #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DBITS),
      .STOP_BITS    (SBITS),
      .PARITY_ODD   (ODD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .uart_rx       (uart_rx),
      .uart_tx       (uart_tx),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Serial frame as a bit list: start, data LSB first, optional parity, stop bits left at 1.
   function automatic logic [15:0] buildFrame(input logic [7:0] d);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < DBITS; i++) f[1 + i] = d[i];
`ifdef UART_PARITY_EN
      f[1 + DBITS] = (^d) ^ 1'(ODD);
`endif
      return f;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos <= -1;
      end else if (m_pos < 0) begin
         if (tx_valid) begin
            m_pos   <= 0;
            m_frame <= buildFrame(tx_data);
            if (loopback) rx_q.push_back({tx_data, 1'b0, 1'b0});
         end
      end else if (m_pos == FRAME_CYC - 1) begin
         m_pos <= -1;
      end else begin
         m_pos <= m_pos + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("uart_tx", uart_tx, (m_pos < 0) ? 1'b1 : m_frame[m_pos / CPB]);
         checkOutput("tx_ready", tx_ready, m_pos < 0);
         if (rx_overrun) ovr_seen++;
         if (rx_valid && rx_ready) begin
            if (rx_q.size() == 0) begin
               checkOutput("rx_unexpected_byte", rx_valid, 1'b0);
            end else begin
               exp_item = rx_q.pop_front();
               checkOutput("rx_byte_flags", {rx_data, rx_frame_err, rx_parity_err}, exp_item);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyTxByte(input logic [7:0] d);
      bit done;
      done = 1'b0;
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 0; i < 2 * FRAME_CYC && !done; i++) begin
         @(negedge clk);
         if (tx_ready) done = 1'b1;
      end
      tick();
      tx_valid = 1'b0;
      if (!done) checkOutput("tx_accept_timeout", tx_ready, 1'b1);
   endtask

   // Drives one frame on rx_line; a low stop bit can be stretched by hold_low extra cycles.
   task automatic applyStimulus(input logic [7:0] d, input logic stop_bit, input int hold_low);
      rx_line = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < DBITS; i++) begin
         rx_line = d[i];
         repeat (CPB) tick();
      end
`ifdef UART_PARITY_EN
      rx_line = par_ovr_en ? par_force : ((^d) ^ 1'(ODD));
      repeat (CPB) tick();
`endif
      rx_line = stop_bit;
      repeat (CPB) tick();
      repeat (hold_low) tick();
      rx_line = 1'b1;
      repeat (2 * CPB) tick();
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 4 * FRAME_CYC && rx_q.size() != 0; i++) tick();
      checkOutput(name, rx_q.size(), 0);
   endtask

   task automatic txLiteralCheck();
      int  k;
      bit  got;
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 2 * FRAME_CYC && !got; i++) begin
         @(negedge clk);
         if (tx_ready) got = 1'b1;
      end
      if (!got) checkOutput("tx55_accept_timeout", tx_ready, 1'b1);
      k = 0;
      got = 1'b0;
      for (int i = 0; i < 2 * FRAME_CYC && !got; i++) begin
         @(negedge clk);
         k++;
         if (k == 1)   tx_valid = 1'b0;
         if (k == 8)   checkOutput("tx55_start", uart_tx, 1'b0);
         if (k == 24)  checkOutput("tx55_bit0", uart_tx, 1'b1);
         if (k == 40)  checkOutput("tx55_bit1", uart_tx, 1'b0);
         if (k == 136) checkOutput("tx55_bit7", uart_tx, 1'b0);
         if (k == 152) checkOutput("tx55_stop", uart_tx, 1'b1);
         if (tx_ready) got = 1'b1;
      end
      checkOutput("tx55_ready_latency", k, 161);
   endtask

   initial begin
      int ovr_base;
      repeat (2) @(negedge clk);
      checkOutput("reset_uart_tx", uart_tx, 1'b1);
      checkOutput("reset_tx_ready", tx_ready, 1'b1);
      checkOutput("reset_rx_valid", rx_valid, 1'b0);
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_errors", {rx_frame_err, rx_parity_err, rx_overrun}, 3'b000);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      $display("[TB] TX literal frame and loopback");
      loopback = 1'b1;
      txLiteralCheck();
      applyTxByte(8'h00);
      applyTxByte(8'hFF);
      applyTxByte(8'hA5);
      repeat (FRAME_CYC + 2 * CPB) tick();
      waitDrain("loopback_drained");
      loopback = 1'b0;

      $display("[TB] false start");
      rx_line = 1'b0;
      repeat (5) tick();
      rx_line = 1'b1;
      repeat (40) tick();
      checkOutput("false_start_rx_valid", rx_valid, 1'b0);
      rx_q.push_back({8'hC3, 1'b0, 1'b0});
      applyStimulus(8'hC3, 1'b1, 0);
      waitDrain("after_false_start_drained");

      $display("[TB] overrun");
      ovr_base = ovr_seen;
      rx_ready = 1'b0;
      rx_q.push_back({8'h12, 1'b0, 1'b0});
      applyStimulus(8'h12, 1'b1, 0);
      applyStimulus(8'h34, 1'b1, 0);
      checkOutput("overrun_rx_valid_held", rx_valid, 1'b1);
      checkOutput("overrun_rx_data_kept", rx_data, 8'h12);
      checkOutput("overrun_pulses", ovr_seen - ovr_base, 1);
      rx_ready = 1'b1;
      waitDrain("overrun_drained");

      $display("[TB] frame error and break");
      rx_q.push_back({8'h3C, 1'b1, 1'b0});
      applyStimulus(8'h3C, 1'b0, 100);
      waitDrain("frame_err_drained");
      rx_q.push_back({8'h5A, 1'b0, 1'b0});
      applyStimulus(8'h5A, 1'b1, 0);
      waitDrain("after_break_drained");

`ifdef UART_PARITY_EN
      $display("[TB] parity");
      par_ovr_en = 1'b1;
      par_force  = 1'b0;
      rx_q.push_back({8'h07, 1'b0, 1'b1});
      applyStimulus(8'h07, 1'b1, 0);
      par_force  = 1'b1;
      rx_q.push_back({8'h07, 1'b0, 1'b0});
      applyStimulus(8'h07, 1'b1, 0);
      par_ovr_en = 1'b0;
      waitDrain("parity_drained");
`endif

      $display("[TB] reset mid-frame");
      applyTxByte(8'hF0);
      repeat (40) tick();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("reset_async_uart_tx", uart_tx, 1'b1);
      checkOutput("reset_async_tx_ready", tx_ready, 1'b1);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3 * CPB) tick();
      checkOutput("reset_no_partial_byte", rx_valid, 1'b0);
      waitDrain("final_drained");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got time limit, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
